// File: rtl/sddr_pkg.sv
// sddr_pkg: shared register map, reset_state bits, DDR3 command encodings and sequencer states
package sddr_pkg;
  localparam logic [15:0] REG_RESET_STATE = 16'h0000;
  localparam logic [15:0] REG_OVR_CMD     = 16'h0004;
  localparam logic [15:0] REG_OVR_ADDR    = 16'h0008;
  localparam int RS_DDR_RESET_N = 0;
  localparam int RS_PHY_RESET_N = 1;
  localparam int RS_BYPASS_N    = 3;
  localparam int RS_ODT         = 4;
  localparam int RS_CKE         = 5;
  localparam logic [31:0] RS_ALL_RESET = 32'h0;
  localparam logic [31:0] RS_RELEASED  = (32'd1 << RS_DDR_RESET_N) | (32'd1 << RS_PHY_RESET_N);
  localparam logic [31:0] RS_CKE_ON    = RS_RELEASED | (32'd1 << RS_CKE);
  localparam logic [31:0] RS_FINAL     = RS_CKE_ON | (32'd1 << RS_BYPASS_N) | (32'd1 << RS_ODT);
  // Command bits are {CS,RAS,CAS,WE}, all active low
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  // ZQCL requires A10 high
  localparam logic [15:0] ZQCL_ADDR = 16'h0400;
  typedef enum logic [3:0] {
    S_WR_RST0, S_WAIT_RST, S_WR_REL, S_WAIT_CKE, S_WR_CKE, S_WAIT_XPR,
    S_WR_ADDR, S_WR_CMD, S_WAIT, S_WR_FINAL, S_DONE
  } state_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sddr_wait_timer.sv
// sddr_wait_timer: loadable down-counter; expired_o is high while the count sits at zero
// Ports: clk, rst (async high), load_i/load_val_i load a new count, expired_o flags zero.
module sddr_wait_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : cnt_q - W'(cnt_q != '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/sddr_init_seq.sv
// sddr_init_seq: DDR3 power-up sequencer owning the sddr_ctrl command bus until init completes
// Ports: cpu_clock_i/reset_i (async high); restart_i reruns init from S_DONE; busy_o/done_o status;
// cpu_cmd_* CPU requests (passed through only when done); ctrl_cmd_* bus to sddr_ctrl.
module sddr_init_seq
  import sddr_pkg::*;
#(
  parameter int          BANK_BITS    = 3,
  parameter int          ROW_BITS     = 13,
  parameter int          T_RESET_CYC  = 20000,
  parameter int          T_CKE_CYC    = 50000,
  parameter int          T_XPR_CYC    = 27,
  parameter int          T_MRD_CYC    = 4,
  parameter int          T_MOD_CYC    = 12,
  parameter int          T_ZQINIT_CYC = 512,
  parameter logic [15:0] MR0          = 16'h0520,
  parameter logic [15:0] MR1          = 16'h0044,
  parameter logic [15:0] MR2          = 16'h0008,
  parameter logic [15:0] MR3          = 16'h0000
) (
  input  logic        cpu_clock_i,
  input  logic        reset_i,
  input  logic        restart_i,
  output logic        busy_o,
  output logic        done_o,
  input  logic        cpu_cmd_valid_i,
  input  logic [15:0] cpu_cmd_address_i,
  input  logic [31:0] cpu_cmd_data_i,
  input  logic        cpu_cmd_write_i,
  output logic        cpu_cmd_ack_o,
  output logic        ctrl_cmd_valid_o,
  output logic [15:0] ctrl_cmd_address_o,
  output logic [31:0] ctrl_cmd_data_o,
  output logic        ctrl_cmd_write_o,
  input  logic        ctrl_cmd_ack_i
);
  localparam int T_MAX = max2(max2(max2(T_RESET_CYC, T_CKE_CYC), max2(T_XPR_CYC, T_MRD_CYC)),
                              max2(T_MOD_CYC, T_ZQINIT_CYC));
  localparam int TW = $clog2(T_MAX + 1);

  state_e         state_q, state_d;
  logic [2:0]     step_q, step_d;
  logic           valid_q, valid_d;
  logic [15:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           load, expired, accept;
  logic [TW-1:0]  load_val;

  // Steps run MR2, MR3, MR1, MR0, then ZQCL
  function automatic logic [31:0] step_addr_word(input logic [2:0] s);
    logic [31:0]          w;
    logic [15:0]          mr;
    logic [BANK_BITS-1:0] ba;
    mr = s == 3'd0 ? MR2 : s == 3'd1 ? MR3 : s == 3'd2 ? MR1 : s == 3'd3 ? MR0 : ZQCL_ADDR;
    ba = s == 3'd0 ? BANK_BITS'(2) : s == 3'd1 ? BANK_BITS'(3) : s == 3'd2 ? BANK_BITS'(1) : '0;
    w = '0;
    w[31 -: BANK_BITS] = ba;
    w[ROW_BITS:0] = mr[ROW_BITS:0];
    return w;
  endfunction

  function automatic logic [TW-1:0] step_wait(input logic [2:0] s);
    return s == 3'd3 ? TW'(T_MOD_CYC - 1) : s == 3'd4 ? TW'(T_ZQINIT_CYC - 1) : TW'(T_MRD_CYC - 1);
  endfunction

  assign accept = valid_q & ctrl_cmd_ack_i;

  // Timer is loaded Tn-1 on accept so the wait state exits, and the next request
  // is registered, exactly Tn edges after the accepting edge.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    load     = 1'b0;
    load_val = '0;
    case (state_q)
      S_WR_RST0:  if (accept) begin state_d = S_WAIT_RST; load = 1'b1; load_val = TW'(T_RESET_CYC - 1); end
      S_WAIT_RST: if (expired) state_d = S_WR_REL;
      S_WR_REL:   if (accept) begin state_d = S_WAIT_CKE; load = 1'b1; load_val = TW'(T_CKE_CYC - 1); end
      S_WAIT_CKE: if (expired) state_d = S_WR_CKE;
      S_WR_CKE:   if (accept) begin state_d = S_WAIT_XPR; load = 1'b1; load_val = TW'(T_XPR_CYC - 1); end
      S_WAIT_XPR: if (expired) state_d = S_WR_ADDR;
      S_WR_ADDR:  if (accept) state_d = S_WR_CMD;
      S_WR_CMD:   if (accept) begin state_d = S_WAIT; load = 1'b1; load_val = step_wait(step_q); end
      S_WAIT:     if (expired) begin
        state_d = step_q < 3'd4 ? S_WR_ADDR : S_WR_FINAL;
        step_d  = step_q < 3'd4 ? step_q + 3'd1 : step_q;
      end
      S_WR_FINAL: if (accept) state_d = S_DONE;
      S_DONE:     if (restart_i) begin state_d = S_WR_RST0; step_d = '0; end
      default:    state_d = S_WR_RST0;
    endcase
    // Request registers follow the next state, so a request stays stable until accepted
    valid_d = state_d inside {S_WR_RST0, S_WR_REL, S_WR_CKE, S_WR_ADDR, S_WR_CMD, S_WR_FINAL};
    addr_d  = state_d == S_WR_ADDR ? REG_OVR_ADDR : state_d == S_WR_CMD ? REG_OVR_CMD : REG_RESET_STATE;
    data_d  = state_d == S_WR_REL   ? RS_RELEASED :
              state_d == S_WR_CKE   ? RS_CKE_ON :
              state_d == S_WR_FINAL ? RS_FINAL :
              state_d == S_WR_ADDR  ? step_addr_word(step_d) :
              state_d == S_WR_CMD   ? {28'b0, step_d == 3'd4 ? CMD_ZQCL : CMD_MRS} : RS_ALL_RESET;
  end

  always_ff @(posedge cpu_clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= S_WR_RST0;
      step_q  <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end

  sddr_wait_timer #(.W(TW)) u_timer (
    .clk        (cpu_clock_i),
    .rst        (reset_i),
    .load_i     (load),
    .load_val_i (load_val),
    .expired_o  (expired)
  );

  assign done_o             = state_q == S_DONE;
  assign busy_o             = !done_o;
  assign cpu_cmd_ack_o      = done_o & ctrl_cmd_ack_i;
  assign ctrl_cmd_valid_o   = done_o ? cpu_cmd_valid_i   : valid_q;
  assign ctrl_cmd_address_o = done_o ? cpu_cmd_address_i : addr_q;
  assign ctrl_cmd_data_o    = done_o ? cpu_cmd_data_i    : data_q;
  assign ctrl_cmd_write_o   = done_o ? cpu_cmd_write_i   : valid_q;
endmodule

// File: tb/tb_sddr_init_seq.sv
// tb_sddr_init_seq: randomized self-checking bench for sddr_init_seq against a write-log model
module tb_sddr_init_seq;
  localparam int TR = 10, TC = 20, TX = 5, TM = 4, TMO = 6, TZ = 8;

  logic        clk = 0, rst = 1, restart = 0, ack = 1;
  logic        cpu_valid = 0, cpu_write = 0;
  logic [15:0] cpu_addr = 0;
  logic [31:0] cpu_data = 0;
  logic        busy, done, cpu_ack, vo, wo;
  logic [15:0] ao;
  logic [31:0] dout;

  int nchk = 0, npass = 0, cyc = 0;
  logic [15:0] q_addr[$], e_addr[$];
  logic [31:0] q_data[$], e_data[$];
  int          q_pres[$], q_acc[$], e_gap[$];
  int          done_edge = -1, unstable = 0, stall_bad = 0;
  logic        pv = 0, pack = 0, pdone = 0;
  logic [15:0] pa;
  logic [31:0] pd;

  sddr_init_seq #(
    .T_RESET_CYC(TR), .T_CKE_CYC(TC), .T_XPR_CYC(TX),
    .T_MRD_CYC(TM), .T_MOD_CYC(TMO), .T_ZQINIT_CYC(TZ)
  ) dut (
    .cpu_clock_i(clk), .reset_i(rst), .restart_i(restart), .busy_o(busy), .done_o(done),
    .cpu_cmd_valid_i(cpu_valid), .cpu_cmd_address_i(cpu_addr), .cpu_cmd_data_i(cpu_data),
    .cpu_cmd_write_i(cpu_write), .cpu_cmd_ack_o(cpu_ack),
    .ctrl_cmd_valid_o(vo), .ctrl_cmd_address_o(ao), .ctrl_cmd_data_o(dout),
    .ctrl_cmd_write_o(wo), .ctrl_cmd_ack_i(ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log each distinct own request: first-presented edge and accept edge
  always @(negedge clk) begin
    if (!rst && busy) begin
      if (pv && !pack && !(vo && ao === pa && dout === pd && wo)) unstable++;
      if (vo && (!pv || pack)) begin
        q_addr.push_back(ao);
        q_data.push_back(dout);
        q_pres.push_back(cyc);
        if (wo !== 1'b1) unstable++;
      end
      if (vo && ack) q_acc.push_back(cyc + 1);
      if (cpu_ack) stall_bad++;
      pv = vo; pack = vo && ack; pa = ao; pd = dout;
    end else begin
      pv = 0; pack = 0;
    end
    if (done && !pdone) done_edge = cyc;
    pdone = done;
  end

  task automatic push_exp(input logic [15:0] a, input logic [31:0] d, input int g);
    e_addr.push_back(a); e_data.push_back(d); e_gap.push_back(g);
  endtask

  // Expected write log: reset_state writes, five (addr,cmd) pairs, final write
  task automatic build_model();
    int mr[5] = '{'h0008, 'h0000, 'h0044, 'h0520, 'h0400};
    int ba[5] = '{2, 3, 1, 0, 0};
    int wt[5] = '{TM, TM, TM, TMO, TZ};
    push_exp(16'h0, 32'h00, 0);
    push_exp(16'h0, 32'h03, TR);
    push_exp(16'h0, 32'h23, TC);
    for (int s = 0; s < 5; s++) begin
      push_exp(16'h8, (32'(ba[s]) << 29) | (32'(mr[s]) & 32'h3FFF), s == 0 ? TX : wt[s-1]);
      push_exp(16'h4, s == 4 ? 32'h6 : 32'h0, 0);
    end
    push_exp(16'h0, 32'h3B, TZ);
  endtask

  task automatic clear_log();
    q_addr.delete(); q_data.delete(); q_pres.delete(); q_acc.delete();
    unstable = 0; stall_bad = 0; done_edge = -1;
  endtask

  task automatic check_sequence(input string tag, input bit rnd, input int stop_at);
    int n = 0;
    while (!done && n < 3000 && !(stop_at > 0 && q_data.size() >= stop_at)) begin
      @(posedge clk); #2; n++;
      if (done) break;
      if (rnd) begin
        ack = $urandom_range(0, 2) != 0;
        cpu_valid = $urandom_range(0, 1);
        cpu_addr = 16'($urandom);
        cpu_data = $urandom;
        cpu_write = 1;
        restart = $urandom_range(0, 7) == 0;
      end
    end
    ack = 1; restart = 0; cpu_valid = 0;
    if (stop_at > 0) begin
      nchk++;
      if (q_data.size() < stop_at) $display("FAIL %s stop_reached got %0d entries need %0d", tag, q_data.size(), stop_at);
      else npass++;
      return;
    end
    @(negedge clk); #1;
    nchk++;
    if (done !== 1'b1) $display("FAIL %s done_timeout got %b need 1", tag, done); else npass++;
    nchk++;
    if (q_data.size() !== 14 || q_acc.size() !== 14)
      $display("FAIL %s log_len got %0d/%0d need 14/14", tag, q_data.size(), q_acc.size());
    else npass++;
    for (int i = 0; i < 14 && i < q_data.size(); i++) begin
      nchk++;
      if (q_addr[i] !== e_addr[i] || q_data[i] !== e_data[i])
        $display("FAIL %s write%0d got %h:%h need %h:%h", tag, i, q_addr[i], q_data[i], e_addr[i], e_data[i]);
      else npass++;
      if (i > 0 && i <= q_acc.size()) begin
        nchk++;
        if (q_pres[i] - q_acc[i-1] !== e_gap[i])
          $display("FAIL %s gap%0d got %0d need %0d", tag, i, q_pres[i] - q_acc[i-1], e_gap[i]);
        else npass++;
      end
    end
    if (q_data.size() == 14) begin
      nchk++;
      if (q_data[7] !== 32'h20000044 || q_data[11] !== 32'h00000400 || q_data[12] !== 32'h6)
        $display("FAIL %s mr1_zq_words got %h %h %h need 20000044 00000400 00000006", tag, q_data[7], q_data[11], q_data[12]);
      else npass++;
    end
    if (q_acc.size() == 14) begin
      nchk++;
      if (done_edge !== q_acc[13]) $display("FAIL %s done_edge got %0d need %0d", tag, done_edge, q_acc[13]);
      else npass++;
    end
    nchk++;
    if (unstable !== 0) $display("FAIL %s request_stability got %0d need 0", tag, unstable); else npass++;
    nchk++;
    if (stall_bad !== 0) $display("FAIL %s cpu_ack_while_busy got %0d need 0", tag, stall_bad); else npass++;
  endtask

  task automatic test_reset();
    rst = 1; cpu_valid = 1; cpu_addr = 16'h8; cpu_data = 32'h1234; cpu_write = 1; ack = 1;
    @(negedge clk);
    nchk++; if (busy !== 1'b1) $display("FAIL reset_busy got %b need 1", busy); else npass++;
    nchk++; if (done !== 1'b0) $display("FAIL reset_done got %b need 0", done); else npass++;
    nchk++; if (vo !== 1'b0 || dout !== 32'h0) $display("FAIL reset_ctrl got %b:%h need 0:0", vo, dout); else npass++;
    nchk++; if (cpu_ack !== 1'b0) $display("FAIL reset_cpu_ack got %b need 0", cpu_ack); else npass++;
    cpu_valid = 0;
  endtask

  task automatic test_sequence_tied();
    clear_log();
    @(posedge clk); #2; rst = 0;
    check_sequence("tied", 0, 0);
  endtask

  task automatic test_passthrough();
    logic [15:0] a;
    logic [31:0] d;
    logic        w, k;
    @(posedge clk); #2;
    cpu_valid = 1; cpu_addr = 16'h0008; cpu_data = 32'h1234; cpu_write = 1; ack = 1; #1;
    nchk++;
    if (vo !== 1'b1 || ao !== 16'h0008 || dout !== 32'h1234 || wo !== 1'b1 || cpu_ack !== 1'b1)
      $display("FAIL pass_beat got %b %h %h %b ack %b need 1 0008 00001234 1 ack 1", vo, ao, dout, wo, cpu_ack);
    else npass++;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      a = 16'($urandom); d = $urandom; w = 1'($urandom); k = 1'($urandom);
      cpu_valid = 1; cpu_addr = a; cpu_data = d; cpu_write = w; ack = k; #1;
      nchk++;
      if (ao !== a || dout !== d || wo !== w || cpu_ack !== k)
        $display("FAIL pass_rand%0d got %h %h %b %b need %h %h %b %b", i, ao, dout, wo, cpu_ack, a, d, w, k);
      else npass++;
    end
    cpu_valid = 0; ack = 1;
  endtask

  task automatic test_restart();
    logic [31:0] d;
    clear_log();
    @(posedge clk); #2;
    d = $urandom;
    restart = 1; cpu_valid = 1; cpu_addr = 16'h0010; cpu_data = d; cpu_write = 1; #1;
    nchk++;
    if (vo !== 1'b1 || dout !== d) $display("FAIL restart_beat got %b:%h need 1:%h", vo, dout, d); else npass++;
    @(posedge clk); #2;
    restart = 0; cpu_valid = 0;
    nchk++;
    if (busy !== 1'b1 || done !== 1'b0) $display("FAIL restart_status got busy %b done %b need 1 0", busy, done);
    else npass++;
    check_sequence("restart", 1, 0);
  endtask

  task automatic test_reset_mid();
    clear_log();
    @(posedge clk); #2; restart = 1;
    @(posedge clk); #2; restart = 0;
    check_sequence("mid_pre", 0, 8);
    rst = 1; #1;
    nchk++;
    if (busy !== 1'b1 || done !== 1'b0 || vo !== 1'b0)
      $display("FAIL mid_reset got busy %b done %b valid %b need 1 0 0", busy, done, vo);
    else npass++;
    repeat (3) @(posedge clk);
    #2; clear_log(); rst = 0;
    check_sequence("after_reset", 1, 0);
  endtask

  initial begin
    build_model();
    test_reset();
    test_sequence_tied();
    test_passthrough();
    test_restart();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
